// File: rtl/sram_like_mem_slave.sv
// Responder end of the SRAM-like req/addr_ok/data_ok interface: word-addressed memory
// answering pipelined requests strictly in order after a fixed latency.
module sram_like_mem_slave #(
   parameter int unsigned ADDR_WIDTH = 12,
   parameter int unsigned LATENCY    = 2,
   parameter int unsigned MAX_OUTS   = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req,
   input  logic        wr,
   input  logic [1:0]  size,
   input  logic [3:0]  wstrb,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic        addr_ok,
   output logic        data_ok,
   output logic [31:0] rdata
);

   localparam int unsigned PTR_W = (MAX_OUTS > 1) ? $clog2(MAX_OUTS) : 1;
   localparam int unsigned CNT_W = $clog2(MAX_OUTS + 1);
   localparam logic [2:0]       TIMER_INIT = 3'(LATENCY - 1);
   localparam logic [PTR_W-1:0] PTR_LAST   = PTR_W'(MAX_OUTS - 1);
   localparam logic [CNT_W-1:0] CNT_MAX    = CNT_W'(MAX_OUTS);

   logic [31:0] mem [0:(1 << ADDR_WIDTH) - 1];

   logic             q_wr    [MAX_OUTS];
   logic [31:0]      q_data  [MAX_OUTS];
   logic [2:0]       q_timer [MAX_OUTS];
   logic [PTR_W-1:0] head, tail;
   logic [CNT_W-1:0] count;

   logic                  accept, retire;
   logic [ADDR_WIDTH-1:0] word_idx;
   logic                  unused_bits;

   // Byte offset and bits above the memory size are don't-care; upper bits alias.
   assign word_idx    = addr[ADDR_WIDTH+1:2];
   assign unused_bits = ^{size, addr[1:0], addr[31:ADDR_WIDTH+2]};

   function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
      return (p == PTR_LAST) ? '0 : p + 1'b1;
   endfunction

   // Full-ness is judged on the registered count only, so a retiring head
   // does not reopen addr_ok until the following cycle.
   always_comb begin
      addr_ok = !reset && (count < CNT_MAX);
      accept  = req && addr_ok;
      retire  = !reset && (count != '0) && (q_timer[head] == '0);
      data_ok = retire;
      rdata   = (retire && !q_wr[head]) ? q_data[head] : '0;
   end

   always_ff @(posedge clk) begin
      if (accept && wr) begin
         for (int unsigned b = 0; b < 4; b++) begin
            if (wstrb[b]) mem[word_idx][8*b +: 8] <= wdata[8*b +: 8];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
         for (int unsigned i = 0; i < MAX_OUTS; i++) begin
            q_wr[i]    <= 1'b0;
            q_data[i]  <= '0;
            q_timer[i] <= '0;
         end
      end else begin
         for (int unsigned i = 0; i < MAX_OUTS; i++) begin
            if (q_timer[i] != '0) q_timer[i] <= q_timer[i] - 1'b1;
         end
         // The accepting slot is always free, so this load wins over the decrement above.
         if (accept) begin
            q_wr[tail]    <= wr;
            q_data[tail]  <= wr ? '0 : mem[word_idx];
            q_timer[tail] <= TIMER_INIT;
            tail          <= next_ptr(tail);
         end
         if (retire) head <= next_ptr(head);
         unique case ({accept, retire})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: tb/tb_sram_like_mem_slave.sv
// Directed bench for sram_like_mem_slave: three instances at LATENCY 2, 4 and 1.
module tb_sram_like_mem_slave;

   logic        clk;
   logic        reset;
   logic [2:0]  req, wr, addr_ok, data_ok;
   logic [1:0]  size  [3];
   logic [3:0]  wstrb [3];
   logic [31:0] addr  [3];
   logic [31:0] wdata [3];
   logic [31:0] rdata [3];

   int n_cmp = 0;
   int n_err = 0;

   logic [31:0] exp_q0 [$];
   logic [31:0] exp_q1 [$];
   logic [31:0] exp_q2 [$];

   sram_like_mem_slave #(.ADDR_WIDTH(12), .LATENCY(2), .MAX_OUTS(4)) dut0 (
      .clk(clk), .reset(reset), .req(req[0]), .wr(wr[0]), .size(size[0]), .wstrb(wstrb[0]),
      .addr(addr[0]), .wdata(wdata[0]), .addr_ok(addr_ok[0]), .data_ok(data_ok[0]), .rdata(rdata[0]));

   sram_like_mem_slave #(.ADDR_WIDTH(12), .LATENCY(4), .MAX_OUTS(4)) dut1 (
      .clk(clk), .reset(reset), .req(req[1]), .wr(wr[1]), .size(size[1]), .wstrb(wstrb[1]),
      .addr(addr[1]), .wdata(wdata[1]), .addr_ok(addr_ok[1]), .data_ok(data_ok[1]), .rdata(rdata[1]));

   sram_like_mem_slave #(.ADDR_WIDTH(12), .LATENCY(1), .MAX_OUTS(4)) dut2 (
      .clk(clk), .reset(reset), .req(req[2]), .wr(wr[2]), .size(size[2]), .wstrb(wstrb[2]),
      .addr(addr[2]), .wdata(wdata[2]), .addr_ok(addr_ok[2]), .data_ok(data_ok[2]), .rdata(rdata[2]));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout required completion");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h required 0x%08h", tag, got, exp);
      end
   endtask

   task automatic expect_rsp(input int k, input logic [31:0] v);
      case (k)
         0:       exp_q0.push_back(v);
         1:       exp_q1.push_back(v);
         default: exp_q2.push_back(v);
      endcase
   endtask

   function automatic int pend(input int k);
      case (k)
         0:       return exp_q0.size();
         1:       return exp_q1.size();
         default: return exp_q2.size();
      endcase
   endfunction

   // Every response is matched in order against the hand-computed expectations.
   always @(negedge clk) begin
      if (data_ok[0]) begin
         if (exp_q0.size() == 0) check("stray_dok0", 32'(data_ok[0]), 32'd0);
         else                    check("rsp0", rdata[0], exp_q0.pop_front());
      end
      if (data_ok[1]) begin
         if (exp_q1.size() == 0) check("stray_dok1", 32'(data_ok[1]), 32'd0);
         else                    check("rsp1", rdata[1], exp_q1.pop_front());
      end
      if (data_ok[2]) begin
         if (exp_q2.size() == 0) check("stray_dok2", 32'(data_ok[2]), 32'd0);
         else                    check("rsp2", rdata[2], exp_q2.pop_front());
      end
   end

   // Called just after a posedge; returns just after the accepting posedge.
   task automatic issue(input int k, input logic w, input logic [3:0] s,
                        input logic [31:0] a, input logic [31:0] d);
      logic go;
      req[k] = 1'b1; wr[k] = w; wstrb[k] = s; addr[k] = a; wdata[k] = d; size[k] = 2'd2;
      go = 1'b0;
      for (int i = 0; i < 20 && !go; i++) begin
         @(negedge clk);
         go = addr_ok[k];
         @(posedge clk); #1;
      end
      req[k] = 1'b0;
      if (!go) check($sformatf("issue_timeout%0d", k), 32'(addr_ok[k]), 32'd1);
   endtask

   task automatic drain(input int k);
      int left;
      left = pend(k);
      for (int i = 0; i < 40 && left != 0; i++) begin
         @(negedge clk);
         left = pend(k);
      end
      check($sformatf("drain%0d", k), 32'(left), 32'd0);
      @(posedge clk); #1;
   endtask

   initial begin
      int n_acc, cyc, first_drop, first_dok, rise, acc_at_drop, dok_seen;
      logic go;

      reset = 1'b1; req = '0; wr = '0;
      for (int k = 0; k < 3; k++) begin
         size[k] = '0; wstrb[k] = '0; addr[k] = '0; wdata[k] = '0;
      end
      repeat (3) @(posedge clk);
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
         check($sformatf("rst_aok%0d", k), 32'(addr_ok[k]), 32'd0);
         check($sformatf("rst_dok%0d", k), 32'(data_ok[k]), 32'd0);
      end
      check("rst_rdata0", rdata[0], 32'd0);
      @(posedge clk); #1;
      reset = 1'b0;
      @(negedge clk);
      check("rel_aok0", 32'(addr_ok[0]), 32'd1);
      @(posedge clk); #1;

      // Test 1: write then read, LATENCY=2
      expect_rsp(0, 32'd0);
      issue(0, 1'b1, 4'hF, 32'h10, 32'hDEADBEEF);
      expect_rsp(0, 32'hDEADBEEF);
      issue(0, 1'b0, 4'h0, 32'h10, 32'h0);
      @(negedge clk);
      check("t1_wr_dok", 32'(data_ok[0]), 32'd1);
      check("t1_wr_rdata", rdata[0], 32'd0);
      @(negedge clk);
      check("t1_rd_dok", 32'(data_ok[0]), 32'd1);
      check("t1_rd_rdata", rdata[0], 32'hDEADBEEF);
      @(negedge clk);
      check("t1_idle", 32'(data_ok[0]), 32'd0);
      @(posedge clk); #1;

      // Test 2: byte-lane write merge
      expect_rsp(0, 32'd0);
      issue(0, 1'b1, 4'hF, 32'h20, 32'h11223344);
      expect_rsp(0, 32'd0);
      issue(0, 1'b1, 4'b0010, 32'h20, 32'h0000AA00);
      expect_rsp(0, 32'h1122AA44);
      issue(0, 1'b0, 4'h0, 32'h20, 32'h0);
      drain(0);

      // Test 6: upper address bits alias onto word 0
      expect_rsp(0, 32'd0);
      issue(0, 1'b1, 4'hF, 32'h0, 32'h5A5A5A5A);
      expect_rsp(0, 32'h5A5A5A5A);
      issue(0, 1'b0, 4'h0, 32'h4000, 32'h0);
      drain(0);

      // Test 3: six held reads against MAX_OUTS=4, LATENCY=4
      for (int i = 0; i < 6; i++) begin
         expect_rsp(1, 32'd0);
         issue(1, 1'b1, 4'hF, 32'h100 + 32'(4 * i), 32'hA5000000 | 32'(i));
      end
      drain(1);
      for (int i = 0; i < 6; i++) expect_rsp(1, 32'hA5000000 | 32'(i));
      n_acc = 0; cyc = 0; first_drop = -1; first_dok = -1; rise = -1; acc_at_drop = -1;
      req[1] = 1'b1; wr[1] = 1'b0; wstrb[1] = 4'h0; addr[1] = 32'h100;
      while (n_acc < 6 && cyc < 40) begin
         @(negedge clk);
         if (!addr_ok[1] && first_drop < 0) begin
            first_drop  = cyc;
            acc_at_drop = n_acc;
         end
         if (data_ok[1] && first_dok < 0) first_dok = cyc;
         if (first_drop >= 0 && rise < 0 && addr_ok[1]) rise = cyc;
         go = addr_ok[1];
         @(posedge clk); #1;
         if (go) begin
            n_acc++;
            addr[1] = 32'h100 + 32'(4 * n_acc);
         end
         cyc++;
      end
      req[1] = 1'b0;
      check("t3_accepts", 32'(n_acc), 32'd6);
      check("t3_acc_before_full", 32'(acc_at_drop), 32'd4);
      check("t3_drop_vs_first_dok", 32'(first_drop), 32'(first_dok));
      check("t3_rise", 32'(rise), 32'(first_dok + 1));
      drain(1);

      // Test 4: LATENCY=1, alternating write/read every cycle
      req[2] = 1'b1; size[2] = 2'd2; wstrb[2] = 4'hF; addr[2] = 32'h40;
      for (int i = 0; i < 6; i++) begin
         wr[2]    = (i % 2 == 0);
         wdata[2] = 32'h0F0F0000 + 32'(i);
         expect_rsp(2, (i % 2 == 0) ? 32'd0 : 32'h0F0F0000 + 32'(i - 1));
         @(negedge clk);
         check($sformatf("t4_aok%0d", i), 32'(addr_ok[2]), 32'd1);
         if (i > 0) check($sformatf("t4_dok%0d", i), 32'(data_ok[2]), 32'd1);
         @(posedge clk); #1;
      end
      req[2] = 1'b0;
      @(negedge clk);
      check("t4_dok_last", 32'(data_ok[2]), 32'd1);
      @(negedge clk);
      check("t4_idle", 32'(data_ok[2]), 32'd0);
      @(posedge clk); #1;

      // Test 5: reset with three reads pending on the LATENCY=4 instance
      expect_rsp(1, 32'd0);
      issue(1, 1'b1, 4'hF, 32'h30, 32'hCAFEF00D);
      drain(1);
      for (int i = 0; i < 3; i++) issue(1, 1'b0, 4'h0, 32'h30, 32'h0);
      dok_seen = 0;
      reset = 1'b1;
      @(negedge clk);
      check("t5_aok_in_reset", 32'(addr_ok[1]), 32'd0);
      dok_seen += int'(data_ok[1]);
      @(posedge clk); #1;
      reset = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (i == 0) check("t5_aok_after", 32'(addr_ok[1]), 32'd1);
         dok_seen += int'(data_ok[1]);
      end
      check("t5_no_dok", 32'(dok_seen), 32'd0);
      @(posedge clk); #1;
      expect_rsp(1, 32'hCAFEF00D);
      issue(1, 1'b0, 4'h0, 32'h30, 32'h0);
      drain(1);

      check("final_pending", 32'(pend(0) + pend(1) + pend(2)), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
